// File: rtl/dsp_mac_acc_if.sv
// Streaming bus for dsp_mac_acc: operand beat in (valid/ready), result beat out (valid/ready).
interface dsp_mac_acc_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned BW = 18,
  parameter int unsigned PW = 48
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic signed [AW-1:0] a;
  logic signed [BW-1:0] b;
  logic signed [BW-1:0] d;
  logic signed [PW-1:0] c;
  logic [1:0]           pre_op;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] p;
  logic                 ovf;

  modport master (
    output in_valid, in_last, a, b, d, c, pre_op, mode, out_ready,
    input  in_ready, out_valid, p, ovf
  );

  modport slave (
    input  in_valid, in_last, a, b, d, c, pre_op, mode, out_ready,
    output in_ready, out_valid, p, ovf
  );
endinterface

// File: rtl/dsp_mac_acc.sv
// Pipelined signed pre-add / multiply / post-add slice with framed accumulation.
// Optional DSP_MAC_SAT_EN: clamp overflowing results and ACC updates instead of wrapping.
module dsp_mac_acc #(
  parameter int unsigned AW = 18,
  parameter int unsigned BW = 18,
  parameter int unsigned PW = 48
) (
  input logic          clk,
  input logic          rstn,
  dsp_mac_acc_if.slave bus
);
  localparam int unsigned BPW = BW + 1;
  localparam int unsigned MW  = AW + BW + 1;
  localparam int unsigned XW  = PW + 1;

  localparam logic [1:0] PRE_ADD  = 2'b01;
  localparam logic [1:0] PRE_SUB  = 2'b10;
  localparam logic [1:0] MODE_ADD = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_SUB = 2'b11;

  logic                  s1_v, s2_v, s3_v;
  logic signed [AW-1:0]  s1_a, s2_a;
  logic signed [BW-1:0]  s1_b, s1_d;
  logic signed [BPW-1:0] s2_bp;
  logic signed [MW-1:0]  s3_m;
  logic signed [PW-1:0]  s1_c, s2_c, s3_c;
  logic [1:0]            s1_pre, s1_mode, s2_mode, s3_mode;
  logic                  s1_last, s2_last, s3_last;

  logic                  out_valid_q, ovf_q, first_q, ovf_sticky_q;
  logic signed [PW-1:0]  p_q, acc_q;

  logic                  adv;
  logic signed [BPW-1:0] bp_c;
  logic signed [MW-1:0]  m_c;
  logic signed [XW-1:0]  sum_c;
  logic signed [PW-1:0]  res_c;
  logic                  ovf_c;

  // Whole pipeline freezes only while a result sits unaccepted at the output.
  assign adv           = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    bp_c = BPW'(s1_b);
    case (s1_pre)
      PRE_ADD: bp_c = BPW'(s1_d) + BPW'(s1_b);
      PRE_SUB: bp_c = BPW'(s1_d) - BPW'(s1_b);
      default: bp_c = BPW'(s1_b);
    endcase
  end

  assign m_c = MW'(s2_a) * MW'(s2_bp);

  // Post-adder evaluated one bit wider so signed overflow is visible in the top two bits.
  always_comb begin
    sum_c = XW'(s3_m);
    case (s3_mode)
      MODE_ADD: sum_c = XW'(s3_c) + XW'(s3_m);
      MODE_SUB: sum_c = XW'(s3_c) - XW'(s3_m);
      MODE_ACC: sum_c = first_q ? XW'(s3_m) : XW'(acc_q) + XW'(s3_m);
      default:  sum_c = XW'(s3_m);
    endcase
    ovf_c = sum_c[PW] != sum_c[PW-1];
`ifdef DSP_MAC_SAT_EN
    if (ovf_c) res_c = sum_c[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    else       res_c = sum_c[PW-1:0];
`else
    res_c = sum_c[PW-1:0];
`endif
  end

  // S1..S3 operand pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v <= 1'b0; s1_a <= '0; s1_b <= '0; s1_d <= '0; s1_c <= '0;
      s1_pre <= '0; s1_mode <= '0; s1_last <= 1'b0;
      s2_v <= 1'b0; s2_a <= '0; s2_bp <= '0; s2_c <= '0; s2_mode <= '0; s2_last <= 1'b0;
      s3_v <= 1'b0; s3_m <= '0; s3_c <= '0; s3_mode <= '0; s3_last <= 1'b0;
    end else if (adv) begin
      s1_v <= bus.in_valid; s1_a <= bus.a; s1_b <= bus.b; s1_d <= bus.d; s1_c <= bus.c;
      s1_pre <= bus.pre_op; s1_mode <= bus.mode; s1_last <= bus.in_last;
      s2_v <= s1_v; s2_a <= s1_a; s2_bp <= bp_c; s2_c <= s1_c; s2_mode <= s1_mode; s2_last <= s1_last;
      s3_v <= s2_v; s3_m <= m_c; s3_c <= s2_c; s3_mode <= s2_mode; s3_last <= s2_last;
    end
  end

  // S4 output register and frame accumulator; non-accumulate beats bypass ACC/FIRST.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      p_q          <= '0;
      ovf_q        <= 1'b0;
      acc_q        <= '0;
      first_q      <= 1'b1;
      ovf_sticky_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= 1'b0;
      if (s3_v) begin
        if (s3_mode != MODE_ACC) begin
          out_valid_q <= 1'b1;
          p_q         <= res_c;
          ovf_q       <= ovf_c;
        end else if (s3_last) begin
          out_valid_q  <= 1'b1;
          p_q          <= res_c;
          ovf_q        <= ovf_sticky_q | ovf_c;
          acc_q        <= '0;
          first_q      <= 1'b1;
          ovf_sticky_q <= 1'b0;
        end else begin
          acc_q        <= res_c;
          first_q      <= 1'b0;
          ovf_sticky_q <= ovf_sticky_q | ovf_c;
        end
      end
    end
  end
endmodule
